// File: rtl/mure_pkg.sv
// Shared widths and E-Trace itype codes for the retire/trace path.
package mure_pkg;
  localparam int BMAP_LEN  = 31;
  localparam int BCNT_LEN  = 5;
  localparam int ITYPE_LEN = 4;

  localparam logic [BCNT_LEN-1:0] BCNT_MAX = BCNT_LEN'(BMAP_LEN);

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_NONE      = 4'd0,
    ITYPE_EXC       = 4'd1,
    ITYPE_INT       = 4'd2,
    ITYPE_ERET      = 4'd3,
    ITYPE_NT_BRANCH = 4'd4,
    ITYPE_T_BRANCH  = 4'd5,
    ITYPE_UNINF_JMP = 4'd6
  } itype_t;
endpackage

// File: rtl/branch_map.sv
// Accumulates retired branch outcomes (1 = not taken) into a 31-entry map
// that the trace encoder drains by pulsing flush_i.
module branch_map
  import mure_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [ITYPE_LEN-1:0] itype_i,
  input  logic                 flush_i,
  output logic [BMAP_LEN-1:0]  map_o,
  output logic [BCNT_LEN-1:0]  branches_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 overflow_o
);

  logic [BMAP_LEN-1:0] map_q, map_d, base_map;
  logic [BCNT_LEN-1:0] cnt_q, cnt_d, base_cnt;
  logic                ovf_q, ovf_d;
  logic                is_br, nt_bit;

  assign is_br  = valid_i && ((itype_i == ITYPE_NT_BRANCH) || (itype_i == ITYPE_T_BRANCH));
  assign nt_bit = (itype_i == ITYPE_NT_BRANCH);

  // Flush clears first so a simultaneous branch lands at index 0, even when full.
  assign base_map = flush_i ? '0 : map_q;
  assign base_cnt = flush_i ? '0 : cnt_q;

  always_comb begin
    map_d = base_map;
    cnt_d = base_cnt;
    ovf_d = 1'b0;
    if (is_br) begin
      if (base_cnt != BCNT_MAX) begin
        for (int i = 0; i < BMAP_LEN; i++)
          if (BCNT_LEN'(i) == base_cnt) map_d[i] = nt_bit;
        cnt_d = base_cnt + BCNT_LEN'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign full_o     = (cnt_q == BCNT_MAX);
  assign empty_o    = (cnt_q == '0);
  assign overflow_o = ovf_q;

endmodule

// File: doc/branch_map.md
BRANCH_MAP -- requirements
Module: branch_map

Interface
REQ-001 SHALL have no parameters; all widths and itype codes come from mure_pkg.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  one retired instruction presented this cycle (iretire from multiple_retire).
REQ-005 SHALL have port itype_i  input  ITYPE_LEN  itype of that instruction.
REQ-006 SHALL have port flush_i  input  1  encoder emitted a packet carrying the map; clear the map.
REQ-007 SHALL have port map_o  output  BMAP_LEN (31)  accumulated branch outcomes, bit i = branch i in retirement order.
REQ-008 SHALL have port branches_o  output  BCNT_LEN (5)  number of valid bits in map_o, 0..31.
REQ-009 SHALL have port full_o  output  1  branches_o == 31.
REQ-010 SHALL have port empty_o  output  1  branches_o == 0.
REQ-011 SHALL have port overflow_o  output  1  one-cycle pulse: a branch was dropped because the map was full.

Function
REQ-012 A branch is recorded only when valid_i=1 and itype_i is ITYPE_NT_BRANCH (4) or ITYPE_T_BRANCH (5); every other itype, or valid_i=0, leaves the state unchanged.
REQ-013 The recorded bit is 1 for not-taken (itype 4) and 0 for taken (itype 5), per E-Trace encoding.
REQ-014 The bit is written at index branches_o, and branches_o increments by 1; lower bits are never shifted.
REQ-015 All outputs are registered; a branch presented in cycle N is visible on map_o/branches_o in cycle N+1.
REQ-016 Bits at index >= branches_o SHALL read 0.
REQ-017 flush_i without a branch: next cycle map_o=0, branches_o=0.
REQ-018 flush_i with a simultaneous branch: the flush applies first, so next cycle the new bit is at index 0 and branches_o=1. This holds even when full.
REQ-019 A branch while full (branches_o=31) without flush_i is dropped: map and count are unchanged and overflow_o=1 for exactly one cycle.
REQ-020 branches_o never wraps past 31 and never underflows.
REQ-021 full_o and empty_o are decoded from the registered count, with no extra latency.

Reset
REQ-022 While rst_ni=0: map_o=0, branches_o=0, full_o=0, empty_o=1, overflow_o=0, independent of the clock.
REQ-023 Reset asserted mid-accumulation discards all recorded branches; the first branch after release is at index 0.
REQ-024 Inputs are ignored during the cycle in which rst_ni is low.

Structure
REQ-025 mure_pkg SHALL hold BMAP_LEN=31, BCNT_LEN=5, ITYPE_LEN, and the itype_t enum including ITYPE_NT_BRANCH=4 and ITYPE_T_BRANCH=5.
REQ-026 The block SHALL be flat, with no sub-module: one register for the map, one counter register, one overflow flop, and combinational next-state logic.
REQ-027 The block SHALL sit directly downstream of multiple_retire (valid_i=iretire_o, itype_i=itype_o) and feed the trace_encoder packet logic.

Verification
REQ-028 Reset then 3 branches: itype 5,4,4 -> map_o=0b110, branches_o=3, empty_o=0, full_o=0.
REQ-029 Non-branch filtering: itype 0,1,6 with valid_i=1, and itype 4 with valid_i=0 -> map_o=0, branches_o=0, empty_o=1.
REQ-030 31 consecutive itype 4 -> map_o=0x7FFFFFFF, full_o=1; a 32nd itype 5 -> state unchanged, overflow_o high for one cycle only.
REQ-031 Full map plus flush_i together with itype 5 -> next cycle map_o=0, branches_o=1.
REQ-032 Flush only after 7 branches -> next cycle map_o=0, branches_o=0, empty_o=1.
REQ-033 rst_ni pulsed low asynchronously between clock edges after 10 branches -> outputs at reset values immediately; the next itype 4 sets map_o=0b1, branches_o=1.
